// File: rtl/fpnew_pkg.sv
// Shared FPU types: IEEE exception status flags and the divsqrt result-buffer sizing helper.
package fpnew_pkg;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    function automatic int unsigned rbuf_cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fpnew_rbuf_ptr.sv
// Wrapping index 0..DEPTH-1 for the result buffer; advances by one per inc_i, clr_i returns to 0.
module fpnew_rbuf_ptr #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fpnew_divsqrt_result_buffer.sv
// DEPTH-entry registered FIFO behind divsqrt: 1-cycle push-to-valid, ready from occupancy only (no out_ready path).
// FPNEW_DIVSQRT_FFLAGS_ACC_EN adds a sticky OR of popped status flags with a clear input.
module fpnew_divsqrt_result_buffer
    import fpnew_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter type TagType = logic,
    localparam int unsigned CNT_W = rbuf_cnt_width(DEPTH),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] result_i,
    input  status_t          status_i,
    input  TagType           tag_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output status_t          status_o,
    output TagType           tag_o,
    output logic [CNT_W-1:0] count_o,
`ifdef FPNEW_DIVSQRT_FFLAGS_ACC_EN
    input  logic             fflags_clr_i,
    output status_t          fflags_acc_o,
`endif
    output logic             busy_o
);

    logic [WIDTH-1:0] res_q [DEPTH];
    status_t          sts_q [DEPTH];
    TagType           tag_q [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push, pop;

    assign in_ready_o  = (count_q != CNT_W'(DEPTH)) & ~rst_i;
    assign out_valid_o = (count_q != '0) & ~flush_i;
    assign push        = in_valid_i & in_ready_o & ~flush_i;
    assign pop         = out_valid_o & out_ready_i;

    fpnew_rbuf_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (flush_i),
        .inc_i (push),
        .ptr_o (wr_ptr)
    );

    fpnew_rbuf_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (flush_i),
        .inc_i (pop),
        .ptr_o (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                res_q[i] <= '0;
                sts_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (push) begin
            res_q[wr_ptr] <= result_i;
            sts_q[wr_ptr] <= status_i;
            tag_q[wr_ptr] <= tag_i;
        end
    end

    assign result_o = res_q[rd_ptr];
    assign status_o = sts_q[rd_ptr];
    assign tag_o    = tag_q[rd_ptr];
    assign count_o  = count_q;
    assign busy_o   = (count_q != '0);

`ifdef FPNEW_DIVSQRT_FFLAGS_ACC_EN
    status_t acc_q, acc_d;

    // Clear takes effect before the OR, so a same-cycle pop seeds the fresh value.
    always_comb begin
        acc_d = fflags_clr_i ? '0 : acc_q;
        if (pop) acc_d = acc_d | status_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign fflags_acc_o = acc_q;
`endif

endmodule

// File: tb/tb_fpnew_divsqrt_result_buffer.sv
module tb_fpnew_divsqrt_result_buffer;

    localparam int W = 64;
    localparam int D = 4;
    typedef logic [7:0] tag_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic          fclr = 1'b0;
    logic [W-1:0]  res_in = '0;
    logic [4:0]    sts_in = '0;
    tag_t          tag_in = '0;
    logic          in_ready, out_valid, busy;
    logic [W-1:0]  res_out;
    logic [4:0]    sts_out;
    tag_t          tag_out;
    logic [2:0]    count;
    logic [4:0]    acc_out;

    fpnew_divsqrt_result_buffer #(.WIDTH(W), .DEPTH(D), .TagType(tag_t)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .result_i     (res_in),
        .status_i     (sts_in),
        .tag_i        (tag_in),
        .flush_i      (flush),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .result_o     (res_out),
        .status_o     (sts_out),
        .tag_o        (tag_out),
        .count_o      (count),
`ifdef FPNEW_DIVSQRT_FFLAGS_ACC_EN
        .fflags_clr_i (fclr),
        .fflags_acc_o (acc_out),
`endif
        .busy_o       (busy)
    );

`ifndef FPNEW_DIVSQRT_FFLAGS_ACC_EN
    assign acc_out = '0;
`endif

    always #5 clk = ~clk;

    int vecs = 0;
    int miss = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an ordinary queue of results plus a sticky flag word.
    typedef struct {
        logic [W-1:0] r;
        logic [4:0]   s;
        tag_t         t;
    } ent_t;
    ent_t       q[$];
    logic [4:0] acc_m = '0;

    always @(posedge clk) begin : model
        bit do_push, do_pop;
        if (rst) begin
            q.delete();
            acc_m = '0;
        end else begin
            do_pop  = (q.size() != 0) && !flush && out_ready;
            do_push = in_valid && (q.size() != D) && !flush;
            if (fclr) acc_m = '0;
            if (do_pop) begin
                acc_m = acc_m | q[0].s;
                q.delete(0);
            end
            if (do_push) q.push_back('{res_in, sts_in, tag_in});
            if (flush) q.delete();
        end
    end

    always @(negedge clk) begin
        chk("out_valid", out_valid, (q.size() != 0) && !flush);
        chk("in_ready", in_ready, (q.size() != D) && !rst);
        chk("count", count, q.size());
        chk("busy", busy, q.size() != 0);
        if (q.size() != 0 && !flush) begin
            chk("head_result", res_out, q[0].r);
            chk("head_status", sts_out, q[0].s);
            chk("head_tag", tag_out, q[0].t);
        end
`ifdef FPNEW_DIVSQRT_FFLAGS_ACC_EN
        chk("fflags_acc", acc_out, acc_m);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [W-1:0] r, input logic [4:0] s, input tag_t t);
        in_valid = 1'b1;
        res_in   = r;
        sts_in   = s;
        tag_in   = t;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_in_ready_low", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_result", res_out, 0);
        chk("rst_acc", acc_out, 0);

        for (int i = 1; i <= 4; i++) push1(64'(i), 5'(i), tag_t'(i));
        chk("fill_count", count, 4);
        chk("fill_in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_result", res_out, 64'(i));
            step();
        end
        chk("drain_empty", out_valid, 0);

        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            res_in   = 64'(100 + k);
            sts_in   = 5'(k);
            tag_in   = tag_t'(k);
            step();
            chk("wrap_tag", tag_out, 64'(k));
            chk("wrap_count_le1", count <= 1, 1);
        end
        in_valid = 1'b0;
        step();
        chk("wrap_empty", out_valid, 0);
        out_ready = 1'b0;

        push1(64'h11, 5'h0, 8'h11);
        push1(64'h12, 5'h0, 8'h12);
        push1(64'h13, 5'h0, 8'h13);
        chk("pre_flush_count", count, 3);
        in_valid = 1'b1;
        res_in   = 64'h99;
        tag_in   = 8'h99;
        flush    = 1'b1;
        #1;
        chk("flush_cycle_valid", out_valid, 0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("post_flush_count", count, 0);
        chk("post_flush_valid", out_valid, 0);
        push1(64'hA, 5'h0, 8'hA);
        chk("after_flush_result", res_out, 64'hA);
        chk("after_flush_count", count, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("after_flush_empty", out_valid, 0);

        for (int i = 0; i < 4; i++) push1(64'(8'h21 + i), 5'h0, tag_t'(8'h21 + i));
        in_valid  = 1'b1;
        res_in    = 64'h55;
        tag_in    = 8'h55;
        out_ready = 1'b1;
        #1;
        chk("full_in_ready", in_ready, 0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("full_pop_count", count, 3);
        chk("full_pop_head", res_out, 64'h22);
        out_ready = 1'b1;
        step();
        step();
        step();
        out_ready = 1'b0;
        chk("full_drained", out_valid, 0);

`ifdef FPNEW_DIVSQRT_FFLAGS_ACC_EN
        fclr = 1'b1;
        step();
        fclr = 1'b0;
        chk("acc_cleared", acc_out, 0);
        push1(64'h1, 5'b00001, 8'h31);
        push1(64'h2, 5'b10000, 8'h32);
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        chk("acc_or", acc_out, 5'b10001);
        push1(64'h3, 5'b00100, 8'h33);
        out_ready = 1'b1;
        fclr      = 1'b1;
        step();
        fclr      = 1'b0;
        out_ready = 1'b0;
        chk("acc_clr_pop", acc_out, 5'b00100);
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/fpnew_divsqrt_result_buffer.md
# fpnew_divsqrt_result_buffer

Result buffer placed directly downstream of the multi-format divide/square-root unit, between its output handshake and the FPU writeback/arbiter. It decouples the iterative unit from writeback stalls by storing up to DEPTH completed results (value, status flags, tag) in a circular FIFO. The iterative unit can therefore retire and accept its next operation while writeback is blocked. It also optionally accumulates sticky exception flags for retired operations.

## Interface
- WIDTH, 64, result width (max enabled FP width)
- DEPTH, 4, number of entries, ≥1, any integer (not restricted to powers of two)
- TagType, logic, opaque tag type carried with each result
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  reset, synchronous, active-high
- in_valid_i  input  1  upstream result valid
- in_ready_o  output  1  buffer can accept a result
- result_i  input  WIDTH  upstream result value
- status_i  input  5  fpnew_pkg::status_t flags {NV,DZ,OF,UF,NX}
- tag_i  input  TagType  upstream tag
- flush_i  input  1  discard all held and incoming entries
- out_valid_o  output  1  head entry valid
- out_ready_i  input  1  downstream accepts head
- result_o  output  WIDTH  head result
- status_o  output  5  head status
- tag_o  output  TagType  head tag
- count_o  output  $clog2(DEPTH+1)  occupancy
- busy_o  output  1  any entry held
- fflags_clr_i  input  1  clear accumulator (macro only)
- fflags_acc_o  output  5  sticky OR of retired status (macro only)

## Operation
- State: storage array[DEPTH], wr_ptr, rd_ptr (0..DEPTH-1), count (0..DEPTH).
- Push: in_valid_i & in_ready_o & ~flush_i. Writes storage[wr_ptr]; wr_ptr advances.
- Pop: out_valid_o & out_ready_i. rd_ptr advances.
- Pointer wrap: DEPTH-1 → 0.
- in_ready_o = (count != DEPTH) & ~rst_i. No combinational path from out_ready_i. When full, a same-cycle pop does not free a slot until the next cycle.
- out_valid_o = (count != 0) & ~flush_i.
- result_o, status_o, tag_o = storage[rd_ptr]. Driven from registers; no path from the in_* ports.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pop when count is 0: impossible by construction. Push when full: impossible by construction.
- flush_i:
  - Next cycle: count = 0, rd_ptr = wr_ptr = 0.
  - A push presented in the flush cycle is dropped.
  - out_valid_o is 0 in the flush cycle, so no pop occurs.
- busy_o = (count != 0).
- Reset values: count = 0, pointers = 0, storage = 0. Hence out_valid_o = 0, result_o = 0, status_o = 0, tag_o = 0, count_o = 0, busy_o = 0, fflags_acc_o = 0. in_ready_o is 0 while rst_i is high and 1 in the first cycle after release.

## Timing
- Push-to-out_valid_o latency: 1 cycle (no fall-through).
- Throughput: 1 push and 1 pop per cycle sustained when DEPTH ≥ 2. With DEPTH = 1, throughput is 1 result per 2 cycles under continuous traffic.
- flush_i takes priority over push, pop and fflags_clr_i's neighbour, the accumulator OR. It does not affect the accumulator.
- rst_i has priority over flush_i and all other inputs.

## Configuration
- FPNEW_DIVSQRT_FFLAGS_ACC_EN defined:
  - fflags_clr_i and fflags_acc_o exist.
  - Each pop ORs status_o into a 5-bit sticky register.
  - fflags_clr_i zeroes the register.
  - Clear and pop in the same cycle: the register becomes the popped status_o (clear applied first).
  - Reset value: 0.
- FPNEW_DIVSQRT_FFLAGS_ACC_EN undefined: both ports and the register are absent. Exception flags travel only via status_o.

## Structure
- status_t and the flag bit ordering are taken from fpnew_pkg; no new typedefs.
- Add the localparam-style helper CNT_W = $clog2(DEPTH+1) to fpnew_pkg as function rbuf_cnt_width(depth).
- One sub-module, fpnew_rbuf_ptr:
  - Wrapping pointer, inputs: clk_i, rst_i, clr_i, inc_i; parameter DEPTH.
  - Instantiated twice, for wr_ptr and rd_ptr.

## Test plan
- Reset, then idle: out_valid_o = 0, in_ready_o = 1, count_o = 0, result_o = 0.
- DEPTH = 4, push 4 results 0x1…0x4 with out_ready_i = 0 → count_o = 4 and in_ready_o = 0. Then raise out_ready_i → outputs 0x1, 0x2, 0x3, 0x4 on consecutive cycles, then out_valid_o = 0.
- Wrap: continuous push/pop of 10 sequential tags with out_ready_i = 1 → tags emerge in order, count_o stays ≤ 1, pointers wrap twice.
- Flush with count = 3 and a concurrent push → next cycle count_o = 0 and out_valid_o = 0. The pushed entry never appears. A subsequent push of 0xA appears next.
- Full buffer, pop and push in the same cycle → push not accepted (in_ready_o = 0), count_o = 3 the next cycle.
- With macro: pop statuses 5'b00001 then 5'b10000 → fflags_acc_o = 5'b10001. Then clear concurrent with a pop of 5'b00100 → fflags_acc_o = 5'b00100.
